// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller with HI/LO registers.
// Define MDU_DIV0_FAST_EN to finish divide-by-zero after one busy cycle.
module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] mdu_opA,
  input  logic [31:0] mdu_opB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] mul_p;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div0;

  always_comb begin
    a_ext = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext = {{32{sgn_q & b_q[31]}}, b_q};
    mul_p = a_ext * b_ext;
    div0  = (b_q == 32'd0);
    neg_a = sgn_q & a_q[31];
    neg_b = sgn_q & b_q[31];
    abs_a = neg_a ? -a_q : a_q;
    abs_b = neg_b ? -b_q : b_q;
    // keep the divider well-defined; result is discarded on div0
    if (div0) abs_b = 32'd1;
    uq  = abs_a / abs_b;
    ur  = abs_a % abs_b;
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (mdu_op)
              3'd1, 3'd2: begin
                state <= MUL;
                busy  <= 1'b1;
                cnt   <= MUL_CNT;
                a_q   <= mdu_opA;
                b_q   <= mdu_opB;
                sgn_q <= (mdu_op == 3'd1);
              end
              3'd3, 3'd4: begin
                state <= DIV;
                busy  <= 1'b1;
`ifdef MDU_DIV0_FAST_EN
                cnt   <= (mdu_opB == 32'd0) ? 4'd0 : DIV_CNT;
`else
                cnt   <= DIV_CNT;
`endif
                a_q   <= mdu_opA;
                b_q   <= mdu_opB;
                sgn_q <= (mdu_op == 3'd3);
              end
              3'd5: hi <= mdu_opA;
              3'd6: lo <= mdu_opA;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (state == MUL) begin
              hi <= mul_p[63:32];
              lo <= mul_p[31:0];
            end else if (!div0) begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized bench for mdu_ctrl against an arithmetic HI/LO model.
// Directed cases cover the documented corner operations and reset.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = DIV_LAT;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_opA;
  logic [31:0] mdu_opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mdu_op(mdu_op),
    .mdu_opA(mdu_opA),
    .mdu_opB(mdu_opB),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue op at the current negedge; returns in the done cycle (or
  // one cycle after issue for single-cycle / no-op codes).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    longint sa, sb, sp;
    logic [63:0] up;
    logic [31:0] eh, el;
    int lat, n;
    sa = $signed(a);
    sb = $signed(b);
    eh = m_hi;
    el = m_lo;
    lat = 0;
    case (op)
      3'd1: begin
        sp = sa * sb;
        {eh, el} = sp;
        lat = MUL_LAT;
      end
      3'd2: begin
        up = 64'(a) * 64'(b);
        {eh, el} = up;
        lat = MUL_LAT;
      end
      3'd3: begin
        if (b != 0) begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end
        lat = (b == 0) ? DIV0_LAT : DIV_LAT;
      end
      3'd4: begin
        if (b != 0) begin
          el = a / b;
          eh = a % b;
        end
        lat = (b == 0) ? DIV0_LAT : DIV_LAT;
      end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
    start = 1'b1;
    mdu_op = op;
    mdu_opA = a;
    mdu_opB = b;
    @(negedge clk);
    start = 1'b0;
    mdu_op = 3'($urandom);
    mdu_opA = $urandom;
    mdu_opB = $urandom;
    check("done_after_issue", done, 0);
    if (lat == 0) begin
      check("busy_single", busy, 0);
      check("hi_single", hi, eh);
      check("lo_single", lo, el);
    end else begin
      n = 0;
      while (busy && n < 40) begin
        n++;
        if (poke) begin
          start = 1'($urandom);
          mdu_op = 3'd1;
          mdu_opA = $urandom;
          mdu_opB = $urandom;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("latency", 64'(n), 64'(lat));
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("hi_res", hi, eh);
      check("lo_res", lo, el);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int dn;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b0;
    start = 1'b0;
    mdu_op = 3'd0;
    mdu_opA = 32'd0;
    mdu_opB = 32'd0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_hi_k", hi, 32'hFFFFFFFF);
    check("mult_lo_k", lo, 32'hFFFFFFFA);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi_k", hi, 32'hFFFFFFFE);
    check("multu_lo_k", lo, 32'h00000001);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_k", lo, 32'hFFFFFFFD);
    check("div_hi_k", hi, 32'hFFFFFFFF);
    @(negedge clk);
    do_op(3'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_k", lo, 32'd3);
    check("divu_hi_k", hi, 32'd1);
    @(negedge clk);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo_k", lo, 32'h80000000);
    check("ovf_hi_k", hi, 32'h00000000);
    @(negedge clk);
    do_op(3'd5, 32'h12345678, 32'd0, 1'b0);
    do_op(3'd3, 32'd99, 32'd0, 1'b0);
    check("div0_hi_k", hi, 32'h12345678);
    do_op(3'd6, 32'hCAFEF00D, 32'd0, 1'b0);
    do_op(3'd7, 32'h11111111, 32'd5, 1'b0);
    do_op(3'd0, 32'h22222222, 32'd5, 1'b0);
    do_op(3'd1, 32'd1234, 32'hFFFFFF00, 1'b1);

    // reset mid-divide drops the result and any done pulse
    start = 1'b1;
    mdu_op = 3'd3;
    mdu_opA = 32'd1000;
    mdu_opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done_after_rst", 64'(dn), 0);
    do_op(3'd1, 32'd6, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if ($urandom_range(0, 2) != 0) @(negedge clk);
      do_op(rop, ra, rb, 1'($urandom));
    end

    @(negedge clk);
    check("final_done", done, 0);
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, meaning the number of busy cycles of a multiply.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning the number of busy cycles of a divide; legal range is MUL_LAT..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle operation issue strobe.
REQ-006 SHALL have port mdu_op  input  3  operation code: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-op.
REQ-007 SHALL have port mdu_opA  input  32  first operand (rs value).
REQ-008 SHALL have port mdu_opB  input  32  second operand (rt value).
REQ-009 SHALL have port busy  output  1  an operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse on operation completion.
REQ-011 SHALL have port hi  output  32  HI register.
REQ-012 SHALL have port lo  output  32  LO register.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; busy SHALL equal (state != IDLE) as a registered decode.
REQ-014 SHALL sample start, mdu_op and both operands only in IDLE; start while busy SHALL be ignored with no state change.
REQ-015 SHALL latch operands internally at issue so operand changes during busy have no effect.
REQ-016 SHALL, on MULT/MULTU issue at edge t, go to MUL, keep busy high for exactly MUL_LAT cycles, and write the result at edge t+MUL_LAT.
REQ-017 SHALL, on DIV/DIVU issue at edge t, go to DIV, keep busy high for exactly DIV_LAT cycles, and write the result at edge t+DIV_LAT.
REQ-018 SHALL use a 4-bit down-counter loaded with latency-1 at issue and decremented each busy cycle; completion occurs when the counter is 0, which SHALL return the FSM to IDLE.
REQ-019 SHALL assert done for exactly the cycle following the completion edge; hi, lo, and busy=0 SHALL be visible in that same cycle.
REQ-020 SHALL, for MULT, place the signed 64-bit product in {hi,lo}; for MULTU, the unsigned 64-bit product.
REQ-021 SHALL, for DIV, set lo to the signed quotient truncated toward zero and hi to a remainder carrying the dividend's sign; for DIVU, the unsigned quotient and remainder.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, yield lo=0x80000000 and hi=0x00000000.
REQ-023 SHALL, on divide by zero (mdu_opB=0), leave hi and lo unchanged at completion while still pulsing done.
REQ-024 SHALL write mdu_opA into hi (MTHI) or lo (MTLO) at the issue edge, with no busy and no done.
REQ-025 SHALL treat a no-op code with start=1 as no action.
REQ-026 SHALL allow a new start in the same cycle done is high; it is accepted because the FSM is in IDLE.

Reset
REQ-027 SHALL, while reset=0, immediately force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, independent of clk.
REQ-028 SHALL, on reset assertion during MUL/DIV, discard the in-flight result; no done pulse SHALL follow.

Configuration
REQ-029 SHALL, when MDU_DIV0_FAST_EN is defined, complete a divide by zero in 1 busy cycle (done at t+1, hi/lo unchanged).
REQ-030 SHALL, when MDU_DIV0_FAST_EN is not defined, treat a divide by zero with the full DIV_LAT timing of REQ-017 and REQ-023.

Verification
REQ-031 SHALL cover: MULT opA=0xFFFFFFFE, opB=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-032 SHALL cover: MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-033 SHALL cover: DIV opA=0xFFFFFFF9 (-7), opB=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-034 SHALL cover: MTHI 0x12345678, then DIV by 0 -> hi stays 0x12345678; done at t+1 with MDU_DIV0_FAST_EN defined, at t+10 without it.
REQ-035 SHALL cover: second MULT start during busy, with operands changed mid-operation -> ignored; result reflects the first operands only.
REQ-036 SHALL cover: reset asserted at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately; no done; a new MULT after release completes normally.
